// File: rtl/dag_seq.sv
// Block-transfer address sequencer and DAG command-port arbiter.
// The program sequencer always wins; the engine issues only on idle cycles.
module dag_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps_dg_en,
    input  logic             ps_dg_dgsclt,
    input  logic             ps_dg_mdfy,
    input  logic [2:0]       ps_dg_iadd,
    input  logic [2:0]       ps_dg_madd,
    input  logic             bt_start,
    input  logic             bt_dgsclt,
    input  logic [2:0]       bt_iadd,
    input  logic [2:0]       bt_madd,
    input  logic [CNT_W-1:0] bt_cnt,
    input  logic             bt_abort,
    input  logic             bt_stl,
    output logic             dg_en,
    output logic             dg_dgsclt,
    output logic             dg_mdfy,
    output logic [2:0]       dg_iadd,
    output logic [2:0]       dg_madd,
    output logic             bt_vld,
    output logic             bt_busy,
    output logic             bt_done,
    output logic [CNT_W-1:0] bt_rem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_sel;
    logic [2:0]       r_iadd;
    logic [2:0]       r_madd;
    logic [CNT_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;

    logic             w_issue;
    logic             w_last;

    assign w_issue = (r_state == S_RUN) & ~ps_dg_en & ~bt_stl & ~bt_abort;
    assign w_last  = (r_rem <= CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_iadd  <= 3'd0;
            r_madd  <= 3'd0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bt_start) begin
                        if (bt_cnt != '0) begin
                            r_sel   <= bt_dgsclt;
                            r_iadd  <= bt_iadd;
                            r_madd  <= bt_madd;
                            r_rem   <= bt_cnt;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // Abort beats a coinciding final issue.
                    if (bt_abort) begin
                        r_rem   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_issue) begin
                        if (r_rem != '0) begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dg_en     = 1'b0;
        dg_dgsclt = 1'b0;
        dg_mdfy   = 1'b0;
        dg_iadd   = 3'd0;
        dg_madd   = 3'd0;
        if (ps_dg_en) begin
            dg_en     = 1'b1;
            dg_dgsclt = ps_dg_dgsclt;
            dg_mdfy   = ps_dg_mdfy;
            dg_iadd   = ps_dg_iadd;
            dg_madd   = ps_dg_madd;
        end else if (w_issue) begin
            dg_en     = 1'b1;
            dg_dgsclt = r_sel;
            dg_iadd   = r_iadd;
            dg_madd   = r_madd;
        end
    end

    assign bt_vld  = w_issue;
    assign bt_busy = r_busy;
    assign bt_done = r_done;
    assign bt_rem  = r_rem;

endmodule

// File: tb/tb_dag_seq.sv
// Testbench for dag_seq: directed and random transfers against a
// plan-based reference with a behavioural DAG register file.
module tb_dag_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy;
    logic [2:0]  ps_dg_iadd, ps_dg_madd;
    logic        bt_start, bt_dgsclt;
    logic [2:0]  bt_iadd, bt_madd;
    logic [15:0] bt_cnt;
    logic        bt_abort, bt_stl;
    logic        dg_en, dg_dgsclt, dg_mdfy;
    logic [2:0]  dg_iadd, dg_madd;
    logic        bt_vld, bt_busy, bt_done;
    logic [15:0] bt_rem;

    int n_cmp = 0;
    int n_err = 0;

    bit          ps_pat [128];
    bit          stl_pat[128];
    bit          st_pat [128];
    logic [15:0] I_r[16];
    logic [15:0] M_r[16];

    dag_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt),
        .ps_dg_mdfy(ps_dg_mdfy), .ps_dg_iadd(ps_dg_iadd),
        .ps_dg_madd(ps_dg_madd),
        .bt_start(bt_start), .bt_dgsclt(bt_dgsclt),
        .bt_iadd(bt_iadd), .bt_madd(bt_madd), .bt_cnt(bt_cnt),
        .bt_abort(bt_abort), .bt_stl(bt_stl),
        .dg_en(dg_en), .dg_dgsclt(dg_dgsclt), .dg_mdfy(dg_mdfy),
        .dg_iadd(dg_iadd), .dg_madd(dg_madd),
        .bt_vld(bt_vld), .bt_busy(bt_busy), .bt_done(bt_done),
        .bt_rem(bt_rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_pat();
        for (int c = 0; c < 128; c++) begin
            ps_pat[c]  = 1'b0;
            stl_pat[c] = 1'b0;
            st_pat[c]  = 1'b0;
        end
    endtask

    // Call with the DUT idle, at least 1 time unit after a rising edge.
    task automatic run_xfer(input int cnt, input bit sel,
                            input logic [2:0] ia, input logic [2:0] ma,
                            input int ab);
        int          iss_c[$];
        int          n, last, busy_end, done_c, ends, k;
        bit          aborted;
        logic [3:0]  ri;
        logic [15:0] i0, m0, ea;
        logic [8:0]  exp_dg;
        logic        psel, pmd;
        logic [2:0]  pi, pm;
        ri = {sel, ia};
        i0 = I_r[ri];
        m0 = M_r[{sel, ma}];
        n = 0;
        last = 0;
        aborted = 1'b0;
        for (int c = 1; c < 120 && n < cnt; c++) begin
            if (ab == c) begin
                aborted = 1'b1;
                break;
            end
            if (!ps_pat[c] && !stl_pat[c]) begin
                iss_c.push_back(c);
                n++;
                last = c;
            end
        end
        busy_end = aborted ? ab : last;
        done_c   = aborted ? -1 : last + 1;
        ends     = (aborted ? ab : last + 1) + 1;

        bt_start = 1'b1;
        bt_cnt = 16'(cnt);
        bt_dgsclt = sel;
        bt_iadd = ia;
        bt_madd = ma;
        ps_dg_en = 1'b0;
        bt_stl = 1'b0;
        bt_abort = 1'b0;
        @(posedge clk);
        #1;
        bt_start = 1'b0;
        k = 0;
        for (int c = 1; c <= ends; c++) begin
            bit is_iss;
            bit busy;
            is_iss = (k < iss_c.size()) && (iss_c[k] == c);
            busy = (c <= busy_end);
            do begin
                psel = 1'($urandom);
                pi = 3'($urandom);
            end while ({psel, pi} == ri);
            pmd = 1'($urandom);
            pm = 3'($urandom);
            ps_dg_en = ps_pat[c];
            ps_dg_dgsclt = psel;
            ps_dg_mdfy = pmd;
            ps_dg_iadd = pi;
            ps_dg_madd = pm;
            bt_stl = stl_pat[c];
            bt_abort = aborted && (c == ab);
            bt_start = st_pat[c] && busy;
            bt_cnt = bt_start ? 16'($urandom_range(1, 40)) : 16'(cnt);
            bt_dgsclt = 1'($urandom);
            bt_iadd = 3'($urandom);
            bt_madd = 3'($urandom);
            #2;
            if (ps_pat[c])
                exp_dg = {1'b1, psel, pmd, pi, pm};
            else if (is_iss)
                exp_dg = {1'b1, sel, 1'b0, ia, ma};
            else
                exp_dg = 9'd0;
            chk($sformatf("dg c%0d", c),
                {dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd}, exp_dg);
            chk($sformatf("vld c%0d", c), bt_vld, is_iss);
            chk($sformatf("busy c%0d", c), bt_busy, busy);
            chk($sformatf("done c%0d", c), bt_done, c == done_c);
            chk($sformatf("rem c%0d", c), bt_rem,
                busy ? 32'(cnt - k) : 32'd0);
            if (is_iss) begin
                ea = i0 + m0 * 16'(k);
                chk($sformatf("addr k%0d", k),
                    I_r[{dg_dgsclt, dg_iadd}], ea);
                k++;
            end
            if (dg_en && !dg_mdfy)
                I_r[{dg_dgsclt, dg_iadd}] += M_r[{dg_dgsclt, dg_madd}];
            if (c < ends) begin
                @(posedge clk);
                #1;
            end
        end
        ea = i0 + m0 * 16'(n);
        chk("i_final", I_r[ri], ea);
        bt_abort = 1'b0;
        bt_start = 1'b0;
        bt_stl = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            I_r[r] = 16'($urandom);
            M_r[r] = 16'($urandom);
        end
        rst = 1'b1;
        ps_dg_en = 1'b0;
        ps_dg_dgsclt = 1'b0;
        ps_dg_mdfy = 1'b0;
        ps_dg_iadd = 3'd0;
        ps_dg_madd = 3'd0;
        bt_start = 1'b0;
        bt_dgsclt = 1'b0;
        bt_iadd = 3'd0;
        bt_madd = 3'd0;
        bt_cnt = 16'd0;
        bt_abort = 1'b0;
        bt_stl = 1'b0;
        clr_pat();

        // Reset state, with and without a sequencer request
        @(posedge clk);
        #1;
        bt_start = 1'b1;
        bt_cnt = 16'd3;
        #1;
        chk("rst_dg", {dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd}, 9'd0);
        chk("rst_vld", bt_vld, 1'b0);
        chk("rst_busy", bt_busy, 1'b0);
        chk("rst_done", bt_done, 1'b0);
        chk("rst_rem", bt_rem, 16'd0);
        @(posedge clk);
        #1;
        ps_dg_en = 1'b1;
        ps_dg_dgsclt = 1'b1;
        ps_dg_mdfy = 1'b0;
        ps_dg_iadd = 3'd5;
        ps_dg_madd = 3'd6;
        #1;
        chk("rst_ps", {dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd},
            {1'b1, 1'b1, 1'b0, 3'd5, 3'd6});
        chk("rst_busy2", bt_busy, 1'b0);
        bt_start = 1'b0;
        ps_dg_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer
        I_r[0] = 16'h0100;
        M_r[0] = 16'h0004;
        clr_pat();
        run_xfer(4, 1'b0, 3'd0, 3'd0, 0);
        chk("basic_i0", I_r[0], 16'h0110);

        // Priority in cycle 2
        I_r[0] = 16'h0100;
        clr_pat();
        ps_pat[2] = 1'b1;
        run_xfer(4, 1'b0, 3'd0, 3'd0, 0);
        chk("prio_i0", I_r[0], 16'h0110);

        // Stall on the PM bank
        I_r[10] = 16'h2000;
        M_r[9] = 16'h0010;
        clr_pat();
        stl_pat[1] = 1'b1;
        stl_pat[2] = 1'b1;
        run_xfer(3, 1'b1, 3'd2, 3'd1, 0);
        chk("stall_i10", I_r[10], 16'h2030);

        // Zero count, then start while running
        clr_pat();
        run_xfer(0, 1'b0, 3'd1, 3'd1, 0);
        clr_pat();
        st_pat[2] = 1'b1;
        st_pat[3] = 1'b1;
        run_xfer(5, 1'b0, 3'd3, 3'd2, 0);

        // Abort, then an immediate new start
        clr_pat();
        run_xfer(8, 1'b0, 3'd4, 3'd4, 3);
        clr_pat();
        run_xfer(2, 1'b1, 3'd7, 3'd0, 0);
        // Abort coinciding with the last issue
        clr_pat();
        run_xfer(3, 1'b0, 3'd5, 3'd5, 3);

        // Random transfers
        for (int t = 0; t < 24; t++) begin
            int cnt;
            int ab;
            clr_pat();
            cnt = $urandom_range(0, 12);
            for (int c = 1; c < 100; c++) begin
                ps_pat[c]  = ($urandom_range(0, 3) == 0);
                stl_pat[c] = ($urandom_range(0, 3) == 0);
                st_pat[c]  = ($urandom_range(0, 5) == 0);
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cnt + 6) : 0;
            run_xfer(cnt, 1'($urandom), 3'($urandom), 3'($urandom), ab);
        end

        // Asynchronous reset in cycle 2 of a cnt=5 transfer
        bt_start = 1'b1;
        bt_cnt = 16'd5;
        bt_dgsclt = 1'b0;
        bt_iadd = 3'd2;
        bt_madd = 3'd3;
        ps_dg_en = 1'b0;
        @(posedge clk);
        #1;
        bt_start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", bt_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_busy", bt_busy, 1'b0);
        chk("mid_vld", bt_vld, 1'b0);
        chk("mid_rem", bt_rem, 16'd0);
        chk("mid_dg", {dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd}, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #2;
            chk($sformatf("post_rst_done c%0d", c), bt_done, 1'b0);
            chk($sformatf("post_rst_vld c%0d", c), bt_vld, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
